// File: rtl/ov7670_capture_window.sv
// ov7670_capture_window: captures one OV7670 DVP frame, optionally decimated, into a line x column pixel RAM.
// Latency: sensor pins cross a 2-flop pipeline, a pixel is written 3 clocks after its last PCLK rise; readback is 1 clock.
// Backpressure: none, the sensor cannot be stalled; pixels or lines outside the window are dropped and flagged in overflow.
module ov7670_capture_window #(
  parameter int LINES    = 176,
  parameter int COLUMNS  = 288,
  parameter int S_LINE   = 8,
  parameter int S_COLUMN = 9,
  parameter int BPP      = 2,
  parameter int DECIM    = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                VSYNC,
  input  logic                HREF,
  input  logic                PCLK,
  input  logic [7:0]          D,
  input  logic                start,
  input  logic [S_LINE-1:0]   rd_line,
  input  logic [S_COLUMN-1:0] rd_column,
  output logic [8*BPP-1:0]    rd_data,
  output logic                busy,
  output logic                frame_done,
  output logic [S_LINE-1:0]   lines_captured,
  output logic                overflow
);

  localparam int DEPTH = LINES * COLUMNS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = 8 * BPP;
  localparam logic [1:0] DMASK = 2'(DECIM - 1);

  typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_FRAME, CAPTURE, DONE} state_t;

  // sensor pins travel together as {VSYNC, HREF, PCLK, D} so D/HREF stay aligned with PCLK
  logic [10:0] sync1, sync2;
  logic        vs_s, href_s, pclk_s;
  logic [7:0]  d_s;
  logic        vs_q, href_q, pclk_q;

  assign {vs_s, href_s, pclk_s, d_s} = sync2;

  state_t          state;
  logic            byte_phase;
  logic [7:0]      hi_byte;
  logic [1:0]      raw_pix, raw_line;
  logic [S_COLUMN:0] col_idx;
  logic [S_LINE:0]   line_idx;
  logic            line_written;

  logic            pclk_rise, vs_rise, vs_fall, href_fall;
  logic            last_byte, keep_pix, col_ok, line_ok, pix_evt, wr_en, rd_ok;
  logic [15:0]     pix_full;
  logic [PW-1:0]   wr_data;
  logic [AW-1:0]   wr_addr, rd_addr;

  logic [PW-1:0]   mem [DEPTH];

  // two-stage pipeline for the asynchronous sensor pins plus one delay stage for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      vs_q   <= 1'b0;
      href_q <= 1'b0;
      pclk_q <= 1'b0;
    end else begin
      sync1  <= {VSYNC, HREF, PCLK, D};
      sync2  <= sync1;
      vs_q   <= vs_s;
      href_q <= href_s;
      pclk_q <= pclk_s;
    end
  end

  // edge strobes, pixel keep decision and RAM addressing
  always_comb begin
    pclk_rise = pclk_s & ~pclk_q;
    vs_rise   = vs_s & ~vs_q;
    vs_fall   = ~vs_s & vs_q;
    href_fall = ~href_s & href_q;
    last_byte = (BPP == 1) || byte_phase;
    keep_pix  = ((raw_pix & DMASK) == 2'd0) && ((raw_line & DMASK) == 2'd0);
    col_ok    = 32'(col_idx) < COLUMNS;
    line_ok   = 32'(line_idx) < LINES;
    pix_evt   = (state == CAPTURE) && !vs_rise && !href_fall && pclk_rise && href_s;
    wr_en     = pix_evt && last_byte && keep_pix && col_ok && line_ok;
    pix_full  = {hi_byte, d_s};
    wr_data   = pix_full[PW-1:0];
    wr_addr   = AW'(32'(line_idx) * COLUMNS + 32'(col_idx));
    rd_ok     = (32'(rd_line) < LINES) && (32'(rd_column) < COLUMNS);
    rd_addr   = AW'(32'(rd_line) * COLUMNS + 32'(rd_column));
  end

  // capture sequencer: arm, align to a whole frame, assemble/decimate pixels, report
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      lines_captured <= '0;
      byte_phase     <= 1'b0;
      hi_byte        <= '0;
      raw_pix        <= '0;
      raw_line       <= '0;
      col_idx        <= '0;
      line_idx       <= '0;
      line_written   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_VS;
            busy  <= 1'b1;
          end
        end
        WAIT_VS: begin
          // a frame already under way is skipped until the next vertical sync
          if (vs_s) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (vs_fall) begin
            state        <= CAPTURE;
            byte_phase   <= 1'b0;
            raw_pix      <= '0;
            raw_line     <= '0;
            col_idx      <= '0;
            line_idx     <= '0;
            line_written <= 1'b0;
            overflow     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            state          <= DONE;
            frame_done     <= 1'b1;
            lines_captured <= (32'(line_idx) > LINES) ? S_LINE'(LINES) : line_idx[S_LINE-1:0];
          end else if (href_fall) begin
            // an odd trailing byte is dropped by clearing the byte phase here
            byte_phase   <= 1'b0;
            raw_pix      <= '0;
            col_idx      <= '0;
            raw_line     <= raw_line + 2'd1;
            line_written <= 1'b0;
            if (line_written) line_idx <= line_idx + 1'b1;
          end else if (pix_evt) begin
            if (last_byte) begin
              byte_phase <= 1'b0;
              raw_pix    <= raw_pix + 2'd1;
              if (keep_pix) begin
                if (col_ok && line_ok) line_written <= 1'b1;
                else                   overflow     <= 1'b1;
                // column saturates so a long line cannot wrap back into the window
                if (col_ok) col_idx <= col_idx + 1'b1;
              end
            end else begin
              byte_phase <= 1'b1;
              hi_byte    <= d_s;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  // pixel RAM: no reset so a stored frame survives it; read returns pre-write data
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= rd_ok ? mem[rd_addr] : '0;
  end

endmodule
